fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 39 +++
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: PC register handshake, registered instruction ROM
// port, jump flush, and the valid/ready instruction stream toward decode.
interface fetch_stage_if;
  logic [15:0] pc_in;
  logic        pc_inc;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic        flush;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  // Fetch stage side
  modport master (
    input  pc_in,
    input  rom_data,
    input  flush,
    input  instr_ready,
    output pc_inc,
    output rom_addr,
    output instr,
    output instr_pc,
    output instr_valid
  );

  // Surrounding PC register, ROM and decode side
  modport slave (
    output pc_in,
    output rom_data,
    output flush,
    output instr_ready,
    input  pc_inc,
    input  rom_addr,
    input  instr,
    input  instr_pc,
    input  instr_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues reads to a registered ROM at the current PC,
// tags each read with its address, and queues returned words in a small
// circular buffer presented to decode with a valid/ready handshake.
// A read is only launched when the buffer is guaranteed room for it, so the
// queue can never overflow. Flush (jump) and reset discard everything queued
// or in flight.
module fetch_stage #(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  localparam int DATA_W = 16;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  logic [CNT_W-1:0]  r_count;
  logic              r_inflight;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [DATA_W-1:0] r_tag;
  logic [DATA_W-1:0] r_mem_instr [DEPTH];
  logic [DATA_W-1:0] r_mem_pc    [DEPTH];

  logic              w_valid;
  logic              w_pop;
  logic              w_write;
  logic              w_issue;
  logic [CNT_W-1:0]  w_occupancy;

  // Occupancy counts the outstanding read so a launched read always has a slot.
  always_comb begin
    w_valid     = (r_count != '0);
    w_pop       = w_valid & bus.instr_ready;
    w_write     = r_inflight & ~bus.flush;
    w_occupancy = r_count + CNT_W'(r_inflight) - CNT_W'(w_pop);
    w_issue     = reset & ~bus.flush & (w_occupancy < CNT_W'(DEPTH));
  end

  // The ROM reads the live PC; the PC advances on the same edge the read launches.
  always_comb begin
    bus.rom_addr    = bus.pc_in;
    bus.pc_inc      = w_issue;
    bus.instr_valid = w_valid;
    bus.instr       = w_valid ? r_mem_instr[r_rd_ptr] : '0;
    bus.instr_pc    = w_valid ? r_mem_pc[r_rd_ptr]    : '0;
  end

  // Control state: occupancy, pointers, outstanding-read flag and its address tag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_tag      <= '0;
    end else if (bus.flush) begin
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag <= bus.pc_in;
      end
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_write) - CNT_W'(w_pop);
    end
  end

  // Buffer storage: returned word and its fetch address land at the tail.
  always_ff @(posedge clk) begin
    if (reset && w_write) begin
      r_mem_instr[r_wr_ptr] <= bus.rom_data;
      r_mem_pc[r_wr_ptr]    <= r_tag;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: models the PC register and a registered ROM
// holding ROM[a] = 16'hA000 + a, and steps through streaming, back-pressure,
// flush, flush-with-pop, mid-stream reset and PC wrap.
module tb_fetch_stage;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc_reg = 16'h0000;
  logic [15:0] rom_q = 16'h0000;
  logic [15:0] tgt;
  int          n_tests = 0;
  int          n_fail  = 0;

  fetch_stage_if bus ();

  fetch_stage #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.pc_in    = pc_reg;
  assign bus.rom_data = rom_q;

  // PC register: jump load wins over increment
  always @(posedge clk) begin
    if (bus.flush)       pc_reg <= tgt;
    else if (bus.pc_inc) pc_reg <= pc_reg + 16'd1;
  end

  // Registered ROM, one cycle read latency
  always @(posedge clk) rom_q <= 16'hA000 + bus.rom_addr;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic chk_head(input string tag, input logic [15:0] ins, input logic [15:0] pc);
    chk({tag, "_valid"}, 16'(bus.instr_valid), 16'h0001);
    chk({tag, "_instr"}, bus.instr, ins);
    chk({tag, "_pc"}, bus.instr_pc, pc);
  endtask

  initial begin
    reset = 1'b0;
    bus.flush = 1'b0;
    bus.instr_ready = 1'b1;
    tgt = 16'h0000;

    // Reset held low for 10 edges
    repeat (10) @(negedge clk);
    #1;
    chk("rst_valid", 16'(bus.instr_valid), 16'h0000);
    chk("rst_instr", bus.instr, 16'h0000);
    chk("rst_instr_pc", bus.instr_pc, 16'h0000);
    chk("rst_pc_inc", 16'(bus.pc_inc), 16'h0000);

    // C0: first reset-high cycle issues immediately
    reset = 1'b1;
    #1;
    chk("c0_pc_inc", 16'(bus.pc_inc), 16'h0001);
    chk("c0_rom_addr", bus.rom_addr, 16'h0000);
    chk("c0_valid", 16'(bus.instr_valid), 16'h0000);
    next(); #1;  // C1
    chk("c1_valid", 16'(bus.instr_valid), 16'h0000);
    chk("c1_pc_inc", 16'(bus.pc_inc), 16'h0001);
    next(); #1;  // C2
    chk_head("c2", 16'hA000, 16'h0000);
    next(); #1;  // C3
    chk_head("c3", 16'hA001, 16'h0001);
    next(); #1;  // C4
    chk_head("c4", 16'hA002, 16'h0002);

    // Back-pressure for 6 cycles (C5..C10): buffer fills to DEPTH, head held
    next(); bus.instr_ready = 1'b0; #1;  // C5
    chk_head("c5", 16'hA003, 16'h0003);
    chk("c5_pc_inc", 16'(bus.pc_inc), 16'h0001);
    next(); #1;  // C6
    chk("c6_pc_inc", 16'(bus.pc_inc), 16'h0001);
    next(); #1;  // C7
    chk("c7_pc_inc", 16'(bus.pc_inc), 16'h0000);
    next(); next(); next(); #1;  // C10
    chk_head("c10_hold", 16'hA003, 16'h0003);
    chk("c10_pc_inc", 16'(bus.pc_inc), 16'h0000);

    // Release: sequence continues without gap or duplicate
    next(); bus.instr_ready = 1'b1; #1;  // C11
    chk_head("c11", 16'hA003, 16'h0003);
    chk("c11_pc_inc", 16'(bus.pc_inc), 16'h0001);
    next(); #1; chk_head("c12", 16'hA004, 16'h0004);
    next(); #1; chk_head("c13", 16'hA005, 16'h0005);
    next(); #1; chk_head("c14", 16'hA006, 16'h0006);
    next(); #1; chk_head("c15", 16'hA007, 16'h0007);

    // C16: flush to 0x0100 with downstream stalled
    next(); bus.instr_ready = 1'b0; bus.flush = 1'b1; tgt = 16'h0100; #1;
    chk("c16_pc_inc", 16'(bus.pc_inc), 16'h0000);
    next(); bus.flush = 1'b0; #1;  // C17
    chk("c17_valid", 16'(bus.instr_valid), 16'h0000);
    next(); #1;  // C18
    chk("c18_valid", 16'(bus.instr_valid), 16'h0000);
    next(); #1;  // C19
    chk_head("c19", 16'hA100, 16'h0100);
    // C20: two buffered, one in flight; jump to 0x1234
    next(); bus.flush = 1'b1; tgt = 16'h1234; #1;
    chk_head("c20", 16'hA100, 16'h0100);
    chk("c20_pc_inc", 16'(bus.pc_inc), 16'h0000);
    next(); bus.flush = 1'b0; bus.instr_ready = 1'b1; #1;  // C21
    chk("c21_valid", 16'(bus.instr_valid), 16'h0000);
    chk("c21_instr", bus.instr, 16'h0000);
    chk("c21_rom_addr", bus.rom_addr, 16'h1234);
    next(); #1;  // C22 (stale ROM word must not appear)
    chk("c22_valid", 16'(bus.instr_valid), 16'h0000);
    next(); #1; chk_head("c23", 16'hB234, 16'h1234);
    next(); #1; chk_head("c24", 16'hB235, 16'h1235);

    // Fill to DEPTH, then flush and pop together
    bus.instr_ready = 1'b0;
    next(); next(); next(); #1;  // C27
    chk_head("c27_full", 16'hB235, 16'h1235);
    chk("c27_pc_inc", 16'(bus.pc_inc), 16'h0000);
    bus.instr_ready = 1'b1; bus.flush = 1'b1; tgt = 16'h2000; #1;
    chk("c27_flush_pc_inc", 16'(bus.pc_inc), 16'h0000);
    next(); bus.flush = 1'b0; #1;  // C28
    chk("c28_valid", 16'(bus.instr_valid), 16'h0000);
    next(); #1;  // C29
    chk("c29_valid", 16'(bus.instr_valid), 16'h0000);
    next(); #1; chk_head("c30", 16'hC000, 16'h2000);

    // Single-cycle reset mid-stream
    next(); reset = 1'b0; #1;  // C31
    chk("c31_pc_inc", 16'(bus.pc_inc), 16'h0000);
    next(); reset = 1'b1; #1;  // C32
    chk("c32_valid", 16'(bus.instr_valid), 16'h0000);
    chk("c32_instr_pc", bus.instr_pc, 16'h0000);
    chk("c32_rom_addr", bus.rom_addr, 16'h2003);
    next(); #1;  // C33
    chk("c33_valid", 16'(bus.instr_valid), 16'h0000);
    next(); #1; chk_head("c34", 16'hC003, 16'h2003);

    // PC wrap from 0xFFFE
    next(); bus.flush = 1'b1; tgt = 16'hFFFE; #1;  // C35
    next(); bus.flush = 1'b0; #1;  // C36
    chk("c36_valid", 16'(bus.instr_valid), 16'h0000);
    next(); next(); #1; chk_head("c38", 16'h9FFE, 16'hFFFE);
    next(); #1; chk_head("c39", 16'h9FFF, 16'hFFFF);
    next(); #1; chk_head("c40", 16'hA000, 16'h0000);
    next(); #1; chk_head("c41", 16'hA001, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
